pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit for the 5-stage Y86-64 core. Combinationally derives per-stage stall/bubble
//  and set_cc from stage icodes, register IDs, e_Cnd and stat codes (load/use, ret, mispredict, exception).
//  Owns the sequential run state (RUN/DRAIN/HALTED), the latched processor status and optional perf counters.
// PARAMETERS
//  CNT_W   32   width of each performance counter
// PORTS
//  clk         in   1      core clock; all state updates on posedge
//  rst_n       in   1      asynchronous reset, active low
//  D_icode     in   4      icode in decode register
//  d_srcA      in   4      decode-stage source A register ID (4'hf = none)
//  d_srcB      in   4      decode-stage source B register ID
//  E_icode     in   4      icode in execute register
//  E_dstM      in   4      execute-stage memory destination register ID
//  e_Cnd       in   1      execute-stage condition result
//  M_icode     in   4      icode in memory register
//  m_stat      in   2      memory-stage status (after dmem error check)
//  W_icode     in   4      icode in writeback register
//  W_stat      in   2      writeback-stage status
//  F_stall     out  1      hold PC / fetch register
//  D_stall     out  1      hold decode register
//  D_bubble    out  1      load nop into decode register
//  E_bubble    out  1      load nop into execute register
//  M_bubble    out  1      load nop into memory register
//  W_stall     out  1      hold writeback register
//  set_cc      out  1      enable CC update in execute
//  cpu_stat    out  2      latched processor status
//  halted      out  1      1 in HALTED state
//  cycle_cnt   out  CNT_W  cycles spent in RUN or DRAIN
//  instr_cnt   out  CNT_W  instructions retired
//  bubble_cnt  out  CNT_W  cycles with E_bubble asserted
// BEHAVIOUR
//  Stat: AOK=2'b00 HLT=2'b01 ADR=2'b10 INS=2'b11. Icodes: HALT=0 NOP=1 MRMOVQ=5 OPQ=6 JXX=7 RET=9 POPQ=B.
//  lu   = (E_icode==MRMOVQ|POPQ) && E_dstM!=4'hf && (E_dstM==d_srcA || E_dstM==d_srcB)
//  ret  = RET in any of D_icode, E_icode, M_icode;  mis = E_icode==JXX && !e_Cnd
//  exc  = m_stat!=AOK || W_stat!=AOK
//  RUN/DRAIN: F_stall=lu|ret; D_stall=lu; D_bubble=mis|(ret&!lu); E_bubble=mis|lu; M_bubble=exc;
//   W_stall=(W_stat!=AOK); set_cc=(E_icode==OPQ)&&!exc. lu+ret: stall D, bubble E, F stalled.
//  HALTED: F_stall=D_stall=W_stall=1; D_bubble=E_bubble=M_bubble=0; set_cc=0 (pipe frozen).
//  FSM (posedge clk): RUN -> HALTED if W_stat!=AOK; else RUN -> DRAIN if m_stat!=AOK; else stay RUN.
//   DRAIN -> HALTED when W_stat!=AOK; else stay DRAIN. HALTED sticky until rst_n low.
//  cpu_stat: AOK in RUN/DRAIN; loaded with W_stat on the edge entering HALTED; held thereafter.
//  halted: registered, 1 from the cycle after W_stat!=AOK is first seen.
//  Reset (rst_n low, async): state=RUN, cpu_stat=AOK, halted=0, counters=0. While rst_n low,
//   combinational outputs: D_bubble=E_bubble=M_bubble=1, others 0.
//  No internal latency on stall/bubble outputs: same-cycle functions of inputs and current state.
// CONFIGURATION
//  PIPE_CTRL_PERF_CNT_EN defined: three CNT_W saturating counters (hold at all-ones):
//   cycle_cnt +1 each cycle in RUN/DRAIN; instr_cnt +1 when W_stat==AOK && W_icode!=NOP and state!=HALTED;
//   bubble_cnt +1 when E_bubble==1. Not defined: counter outputs tied to 0, no counter flops.
// STRUCTURE
//  Shared package y86_pkg: icode constants, stat encodings (STAT_AOK..STAT_INS), RNONE=4'hf,
//   FSM state typedef {ST_RUN, ST_DRAIN, ST_HALTED}.
//  One sub-module: pipe_hazard_detect (pure combinational lu/ret/mis/exc terms); FSM, output
//   muxing and counters live in pipe_ctrl.
// TESTING
//  Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; d_srcA=4 -> all 0.
//  Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0; e_Cnd=1 -> both 0.
//  Ret: D_icode=9 for 3 cycles -> F_stall=1, D_bubble=1 each cycle; with lu also true -> D_stall=1, D_bubble=0.
//  Exception: m_stat=ADR cycle N -> M_bubble=1, set_cc=0, DRAIN at N+1; W_stat=ADR at N+1 -> W_stall=1,
//   halted=1 and cpu_stat=2'b10 at N+2; stays HALTED 20 cycles with W_stat back to AOK.
//  Halt: W_icode=0, W_stat=HLT -> cpu_stat=2'b01, halted=1 next cycle; rst_n pulse low mid-HALTED ->
//   immediate RUN, cpu_stat=AOK, counters 0.
//  Perf (PIPE_CTRL_PERF_CNT_EN, CNT_W=4): 20 RUN cycles -> cycle_cnt saturates at 4'hF; 5 retired
//   non-nop ops -> instr_cnt=5; without macro all counters read 0.

Source files
------------

// File: rtl/y86_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | y86_pkg : shared Y86-64 icode, status and pipe-control FSM encodings        |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  localparam logic [3:0] RNONE = 4'hf;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN    = 2'd0;
  localparam state_t ST_DRAIN  = 2'd1;
  localparam state_t ST_HALTED = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_hazard_detect : combinational load/use, ret, mispredict, exception     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  output logic       lu,
  output logic       ret,
  output logic       mis,
  output logic       exc
);

  always_comb begin
    lu  = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
          (E_dstM != RNONE) &&
          ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mis = (E_icode == I_JXX) && !e_Cnd;
    exc = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl : Y86-64 pipeline control, run/drain/halt FSM, status latch;      |
// |             perf counters built only when PIPE_CTRL_PERF_CNT_EN is defined   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic   w_lu, w_ret, w_mis, w_exc;
  state_t state_q, state_d;
  logic [1:0] cpu_stat_q, cpu_stat_d;

  pipe_hazard_detect u_hazard (
    .D_icode (D_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_icode (E_icode),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .M_icode (M_icode),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .lu      (w_lu),
    .ret     (w_ret),
    .mis     (w_mis),
    .exc     (w_exc)
  );

  // Reset forces bubbles straight through so the pipe registers load nops.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    if (!rst_n) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state_q == ST_HALTED) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      W_stall = 1'b1;
    end else begin
      F_stall  = w_lu | w_ret;
      D_stall  = w_lu;
      D_bubble = w_mis | (w_ret & ~w_lu);
      E_bubble = w_mis | w_lu;
      M_bubble = w_exc;
      W_stall  = (W_stat != STAT_AOK);
      set_cc   = (E_icode == I_OPQ) && !w_exc;
    end
  end

  always_comb begin
    state_d    = state_q;
    cpu_stat_d = cpu_stat_q;
    case (state_q)
      ST_RUN: begin
        if (W_stat != STAT_AOK) begin
          state_d    = ST_HALTED;
          cpu_stat_d = W_stat;
        end else if (m_stat != STAT_AOK) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (W_stat != STAT_AOK) begin
          state_d    = ST_HALTED;
          cpu_stat_d = W_stat;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cpu_stat_q <= STAT_AOK;
    end else begin
      state_q    <= state_d;
      cpu_stat_q <= cpu_stat_d;
    end
  end

  assign cpu_stat = cpu_stat_q;
  assign halted   = (state_q == ST_HALTED);

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             w_running;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    w_running    = (state_q != ST_HALTED);
    cycle_cnt_d  = cycle_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (w_running && (cycle_cnt_q != {CNT_W{1'b1}}))
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (w_running && (W_stat == STAT_AOK) && (W_icode != I_NOP) &&
        (instr_cnt_q != {CNT_W{1'b1}}))
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    if (E_bubble && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_w_icode;
  assign unused_w_icode = ^W_icode;
  assign cycle_cnt  = '0;
  assign instr_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_ctrl : directed-vector bench for pipe_ctrl with a behavioural model |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam int TB_CNT_W = 4;
  localparam int MAXC     = 15;
`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] D_icode = 4'h1, d_srcA = 4'hf, d_srcB = 4'hf;
  logic [3:0] E_icode = 4'h1, E_dstM = 4'hf, M_icode = 4'h1, W_icode = 4'h1;
  logic       e_Cnd = 1'b1;
  logic [1:0] m_stat = 2'b00, W_stat = 2'b00;

  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [1:0] cpu_stat;
  logic [TB_CNT_W-1:0] cycle_cnt, instr_cnt, bubble_cnt;

  int checks = 0;
  int failures = 0;

  pipe_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .cpu_stat(cpu_stat), .halted(halted),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = running, 1 = draining, 2 = halted.
  int         mode;
  logic [1:0] mstat;
  int         mcyc, minstr, mbub;
  logic       lu_m, ret_m, mis_m, exc_m;
  logic       e_F, e_Ds, e_Db, e_Eb, e_Mb, e_W, e_cc;

  always_comb begin
    lu_m  = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hf &&
            (E_dstM == d_srcA || E_dstM == d_srcB);
    ret_m = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mis_m = (E_icode == 4'h7) && !e_Cnd;
    exc_m = (m_stat != 2'b00) || (W_stat != 2'b00);
    e_F = 0; e_Ds = 0; e_Db = 0; e_Eb = 0; e_Mb = 0; e_W = 0; e_cc = 0;
    if (!rst_n) begin
      e_Db = 1; e_Eb = 1; e_Mb = 1;
    end else if (mode == 2) begin
      e_F = 1; e_Ds = 1; e_W = 1;
    end else begin
      e_F  = lu_m || ret_m;
      e_Ds = lu_m;
      e_Db = mis_m || (ret_m && !lu_m);
      e_Eb = mis_m || lu_m;
      e_Mb = exc_m;
      e_W  = (W_stat != 2'b00);
      e_cc = (E_icode == 4'h6) && !exc_m;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= 0; mstat <= 2'b00; mcyc <= 0; minstr <= 0; mbub <= 0;
    end else begin
      if (mode != 2) mcyc <= (mcyc < MAXC) ? mcyc + 1 : mcyc;
      if (mode != 2 && W_stat == 2'b00 && W_icode != 4'h1)
        minstr <= (minstr < MAXC) ? minstr + 1 : minstr;
      if (e_Eb) mbub <= (mbub < MAXC) ? mbub + 1 : mbub;
      if (mode != 2 && W_stat != 2'b00) begin
        mode  <= 2;
        mstat <= W_stat;
      end else if (mode == 0 && m_stat != 2'b00) begin
        mode <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("F_stall",  32'(F_stall),  32'(e_F));
    chk("D_stall",  32'(D_stall),  32'(e_Ds));
    chk("D_bubble", 32'(D_bubble), 32'(e_Db));
    chk("E_bubble", 32'(E_bubble), 32'(e_Eb));
    chk("M_bubble", 32'(M_bubble), 32'(e_Mb));
    chk("W_stall",  32'(W_stall),  32'(e_W));
    chk("set_cc",   32'(set_cc),   32'(e_cc));
    chk("halted",   32'(halted),   32'(mode == 2));
    chk("cpu_stat", 32'(cpu_stat), 32'(mstat));
    chk("cycle_cnt",  32'(cycle_cnt),  PERF ? 32'(mcyc)   : 32'd0);
    chk("instr_cnt",  32'(instr_cnt),  PERF ? 32'(minstr) : 32'd0);
    chk("bubble_cnt", 32'(bubble_cnt), PERF ? 32'(mbub)   : 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_icode = 4'h1; d_srcA = 4'hf; d_srcB = 4'hf; E_icode = 4'h1; E_dstM = 4'hf;
    e_Cnd = 1'b1; M_icode = 4'h1; W_icode = 4'h1; m_stat = 2'b00; W_stat = 2'b00;
  endtask

  initial begin
    idle();
    step(); step(); #1;
    chk("rst_D_bubble", 32'(D_bubble), 32'd1);
    chk("rst_E_bubble", 32'(E_bubble), 32'd1);
    chk("rst_M_bubble", 32'(M_bubble), 32'd1);
    chk("rst_F_stall",  32'(F_stall),  32'd0);
    chk("rst_halted",   32'(halted),   32'd0);
    chk("rst_cpu_stat", 32'(cpu_stat), 32'd0);
    step(); rst_n = 1'b1;
    step(); step();

    // load/use
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    chk("lu_F_stall",  32'(F_stall),  32'd1);
    chk("lu_D_stall",  32'(D_stall),  32'd1);
    chk("lu_E_bubble", 32'(E_bubble), 32'd1);
    chk("lu_D_bubble", 32'(D_bubble), 32'd0);
    d_srcA = 4'h4; #1;
    chk("nolu_F_stall",  32'(F_stall),  32'd0);
    chk("nolu_E_bubble", 32'(E_bubble), 32'd0);
    step(); idle();

    // mispredict
    E_icode = 4'h7; e_Cnd = 1'b0; #1;
    chk("mis_D_bubble", 32'(D_bubble), 32'd1);
    chk("mis_E_bubble", 32'(E_bubble), 32'd1);
    chk("mis_F_stall",  32'(F_stall),  32'd0);
    e_Cnd = 1'b1; #1;
    chk("taken_D_bubble", 32'(D_bubble), 32'd0);
    chk("taken_E_bubble", 32'(E_bubble), 32'd0);
    step(); idle();

    // ret for three cycles, then ret combined with load/use
    D_icode = 4'h9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ret_F_stall",  32'(F_stall),  32'd1);
      chk("ret_D_bubble", 32'(D_bubble), 32'd1);
      step();
    end
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    chk("retlu_D_stall",  32'(D_stall),  32'd1);
    chk("retlu_D_bubble", 32'(D_bubble), 32'd0);
    chk("retlu_E_bubble", 32'(E_bubble), 32'd1);
    step(); idle();

    // OPq sets condition codes
    E_icode = 4'h6; #1;
    chk("opq_set_cc", 32'(set_cc), 32'd1);
    step(); idle();

    // five retired operations
    W_icode = 4'h6;
    repeat (5) step();
    W_icode = 4'h1; #1;
    chk("instr_cnt_5", 32'(instr_cnt), PERF ? 32'd5 : 32'd0);
    repeat (20) step();
    chk("cycle_cnt_sat", 32'(cycle_cnt), PERF ? 32'hF : 32'd0);

    // memory exception -> drain -> halt
    m_stat = 2'b10; E_icode = 4'h6; #1;
    chk("exc_M_bubble", 32'(M_bubble), 32'd1);
    chk("exc_set_cc",   32'(set_cc),   32'd0);
    step();
    W_stat = 2'b10; #1;
    chk("drain_W_stall", 32'(W_stall), 32'd1);
    chk("drain_halted",  32'(halted),  32'd0);
    step();
    chk("adr_halted",   32'(halted),   32'd1);
    chk("adr_cpu_stat", 32'(cpu_stat), 32'd2);
    chk("adr_F_stall",  32'(F_stall),  32'd1);
    chk("adr_set_cc",   32'(set_cc),   32'd0);
    idle();
    repeat (20) step();
    chk("sticky_halted",   32'(halted),   32'd1);
    chk("sticky_cpu_stat", 32'(cpu_stat), 32'd2);

    rst_n = 1'b0; step(); rst_n = 1'b1; step();

    // halt instruction
    W_icode = 4'h0; W_stat = 2'b01;
    step();
    chk("hlt_cpu_stat", 32'(cpu_stat), 32'd1);
    chk("hlt_halted",   32'(halted),   32'd1);
    idle();
    repeat (3) step();
    rst_n = 1'b0; #1;
    chk("arst_halted",     32'(halted),     32'd0);
    chk("arst_cpu_stat",   32'(cpu_stat),   32'd0);
    chk("arst_cycle_cnt",  32'(cycle_cnt),  32'd0);
    chk("arst_instr_cnt",  32'(instr_cnt),  32'd0);
    chk("arst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("arst_D_bubble",   32'(D_bubble),   32'd1);
    step(); rst_n = 1'b1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
